// File: rtl/servo_pkg.sv
// Tick arithmetic and FSM encoding shared by the servo pulse generator and decoder,
// so both ends of the link derive identical preamble and step lengths.
package servo_pkg;

    localparam int MS_NS = 1_000_000;

    localparam int ST_W = 3;
    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_RISE = 3'd1;
    localparam logic [ST_W-1:0] ST_OFFSET    = 3'd2;
    localparam logic [ST_W-1:0] ST_MEASURE   = 3'd3;
    localparam logic [ST_W-1:0] ST_LONG      = 3'd4;

    // Clock cycles in one millisecond (rounded up by one tick).
    function automatic int ms_ticks(input int clk_per_ns);
        return MS_NS / clk_per_ns + 1;
    endfunction

    // Clock cycles per position step when 1 ms is split into 2^n steps.
    function automatic int step_ticks(input int clk_per_ns, input int n);
        return (MS_NS / clk_per_ns) / (1 << n) + 1;
    endfunction

endpackage

// File: rtl/pwm_input_sync.sv
// Two-flop synchroniser for the asynchronous servo input plus a third flop
// that yields single-cycle rise/fall pulses on the synchronised level.
module pwm_input_sync (
    input  logic clk_i,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] r_sync;
    logic       r_prev;

    // No reset: the chain must keep tracking the pin while the decoder is held
    // in reset, so a pulse in progress at release is seen as already high.
    always_ff @(posedge clk_i) begin
        r_sync <= {r_sync[0], pwm_i};
        r_prev <= r_sync[1];
    end

    assign level_o = r_sync[1];
    assign rise_o  = r_sync[1] & ~r_prev;
    assign fall_o  = ~r_sync[1] & r_prev;

endmodule

// File: rtl/servo_pulse_decoder.sv
// Measures the high time of an RC-servo pulse (1 ms preamble + 1 ms span of 2^N steps)
// and returns the N-bit position, with short/long pulse strobes and a loss-of-signal level.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int CLK_PER_NS = 40,
    parameter int N          = 8,
    parameter int TIMEOUT_MS = 25
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         pwm_i,
    output logic [N-1:0] position_o,
    output logic         valid_o,
    output logic         err_short_o,
    output logic         err_long_o,
    output logic         timeout_o
);

    localparam int MS_TICKS   = ms_ticks(CLK_PER_NS);
    localparam int STEP_TICKS = step_ticks(CLK_PER_NS, N);
    localparam int HCNT_W     = $clog2(MS_TICKS + 1);
    localparam int STEP_W     = $clog2(STEP_TICKS + 1);
    localparam int MSC_W      = $clog2(TIMEOUT_MS + 1);

    // The rising-edge cycle itself is the first high cycle, so the preamble
    // completes on the cycle where hcnt steps from MS_TICKS-2 to MS_TICKS-1.
    localparam logic [HCNT_W-1:0] HCNT_LAST = HCNT_W'(MS_TICKS - 2);
    localparam logic [HCNT_W-1:0] TICK_LAST = HCNT_W'(MS_TICKS - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_TICKS - 1);
    localparam logic [N-1:0]      POS_MAX   = '1;
    localparam logic [MSC_W-1:0]  MSC_LIMIT = MSC_W'(TIMEOUT_MS);
    localparam logic [MSC_W-1:0]  MSC_PRE   = MSC_W'(TIMEOUT_MS - 1);

    logic w_level;
    logic w_rise;
    logic w_fall;

    logic [ST_W-1:0]   r_state,    w_state_next;
    logic [HCNT_W-1:0] r_hcnt,     w_hcnt_next;
    logic [STEP_W-1:0] r_stepcnt,  w_stepcnt_next;
    logic [N-1:0]      r_poscnt,   w_poscnt_next;
    logic [HCNT_W-1:0] r_tickcnt,  w_tickcnt_next;
    logic [MSC_W-1:0]  r_mscnt,    w_mscnt_next;
    logic [N-1:0]      r_position, w_position_next;
    logic              r_valid,    w_valid_next;
    logic              r_short,    w_short_next;
    logic              r_long,     w_long_next;
    logic              r_timeout,  w_timeout_next;

    pwm_input_sync u_sync (
        .clk_i   (clk_i),
        .pwm_i   (pwm_i),
        .level_o (w_level),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    always_comb begin
        w_state_next    = r_state;
        w_hcnt_next     = r_hcnt;
        w_stepcnt_next  = r_stepcnt;
        w_poscnt_next   = r_poscnt;
        w_tickcnt_next  = r_tickcnt;
        w_mscnt_next    = r_mscnt;
        w_position_next = r_position;
        w_valid_next    = 1'b0;
        w_short_next    = 1'b0;
        w_long_next     = 1'b0;
        w_timeout_next  = r_timeout;

        if (!en_i) begin
            w_state_next   = ST_IDLE;
            w_hcnt_next    = '0;
            w_stepcnt_next = '0;
            w_poscnt_next  = '0;
            w_tickcnt_next = '0;
            w_mscnt_next   = '0;
        end else begin
            // Loss-of-signal timer; a rising edge beats a coincident threshold.
            if (r_state != ST_IDLE) begin
                if (w_rise) begin
                    w_tickcnt_next = '0;
                    w_mscnt_next   = '0;
                end else if (r_tickcnt == TICK_LAST) begin
                    w_tickcnt_next = '0;
                    if (r_mscnt != MSC_LIMIT) begin
                        w_mscnt_next = r_mscnt + 1'b1;
                        if (r_mscnt == MSC_PRE) begin
                            w_timeout_next = 1'b1;
                        end
                    end
                end else begin
                    w_tickcnt_next = r_tickcnt + 1'b1;
                end
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_level) begin
                        w_state_next = ST_WAIT_RISE;
                    end
                end
                ST_WAIT_RISE: begin
                    if (w_rise) begin
                        w_state_next = ST_OFFSET;
                        w_hcnt_next  = '0;
                    end
                end
                ST_OFFSET: begin
                    if (w_fall) begin
                        w_short_next = 1'b1;
                        w_state_next = ST_WAIT_RISE;
                    end else begin
                        w_hcnt_next = r_hcnt + 1'b1;
                        if (r_hcnt == HCNT_LAST) begin
                            w_state_next   = ST_MEASURE;
                            w_stepcnt_next = '0;
                            w_poscnt_next  = '0;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (w_fall) begin
                        w_position_next = r_poscnt;
                        w_valid_next    = 1'b1;
                        w_timeout_next  = 1'b0;
                        w_state_next    = ST_WAIT_RISE;
                    end else if (r_stepcnt == STEP_LAST) begin
                        w_stepcnt_next = '0;
                        w_poscnt_next  = r_poscnt + 1'b1;
                        if (r_poscnt == POS_MAX) begin
                            w_state_next = ST_LONG;
                        end
                    end else begin
                        w_stepcnt_next = r_stepcnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (w_fall) begin
                        w_long_next  = 1'b1;
                        w_state_next = ST_WAIT_RISE;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_hcnt     <= '0;
            r_stepcnt  <= '0;
            r_poscnt   <= '0;
            r_tickcnt  <= '0;
            r_mscnt    <= '0;
            r_position <= '0;
            r_valid    <= 1'b0;
            r_short    <= 1'b0;
            r_long     <= 1'b0;
            r_timeout  <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_hcnt     <= w_hcnt_next;
            r_stepcnt  <= w_stepcnt_next;
            r_poscnt   <= w_poscnt_next;
            r_tickcnt  <= w_tickcnt_next;
            r_mscnt    <= w_mscnt_next;
            r_position <= w_position_next;
            r_valid    <= w_valid_next;
            r_short    <= w_short_next;
            r_long     <= w_long_next;
            r_timeout  <= w_timeout_next;
        end
    end

    assign position_o  = r_position;
    assign valid_o     = r_valid;
    assign err_short_o = r_short;
    assign err_long_o  = r_long;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Randomised pulse-width bench for servo_pulse_decoder; scaled-down timing keeps runs short
// while the reference model classifies each pulse straight from its high time.
module tb_servo_pulse_decoder;

    localparam int TB_CLK_NS = 4000;
    localparam int TB_N      = 4;
    localparam int TB_TO     = 3;
    localparam int MS        = 1_000_000 / TB_CLK_NS + 1;
    localparam int STEP      = (1_000_000 / TB_CLK_NS) / (2 ** TB_N) + 1;
    localparam int LONG_H    = MS + (2 ** TB_N) * STEP;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            en_i;
    logic            pwm_i;
    logic [TB_N-1:0] position_o;
    logic            valid_o;
    logic            err_short_o;
    logic            err_long_o;
    logic            timeout_o;

    int   checks = 0;
    int   errors = 0;
    int   tot_valid = 0;
    int   tot_short = 0;
    int   tot_long = 0;
    int   exp_pos = 0;
    logic exp_timeout = 1'b1;

    servo_pulse_decoder #(
        .CLK_PER_NS (TB_CLK_NS),
        .N          (TB_N),
        .TIMEOUT_MS (TB_TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .pwm_i       (pwm_i),
        .position_o  (position_o),
        .valid_o     (valid_o),
        .err_short_o (err_short_o),
        .err_long_o  (err_long_o),
        .timeout_o   (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_o)     tot_valid <= tot_valid + 1;
        if (err_short_o) tot_short <= tot_short + 1;
        if (err_long_o)  tot_long  <= tot_long + 1;
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one pulse of h high cycles then gap low cycles, and compare the
    // strobes seen against the outcome predicted from h alone.
    task automatic run_pulse(input int h, input int gap);
        int v0, s0, l0, lat, ev, es, el;
        v0 = tot_valid; s0 = tot_short; l0 = tot_long;
        @(posedge clk); #1 pwm_i = 1'b1;
        repeat (h) @(posedge clk);
        #1 pwm_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= gap; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_o && lat == 0) lat = k;
        end
        #1;
        ev = 0; es = 0; el = 0;
        if (h < MS) es = 1;
        else if (h >= LONG_H) el = 1;
        else begin
            ev = 1;
            exp_pos = (h - MS) / STEP;
            exp_timeout = 1'b0;
        end
        $display("pulse h=%0d -> valid=%0d short=%0d long=%0d pos=%0d timeout=%0d",
                 h, tot_valid - v0, tot_short - s0, tot_long - l0, position_o, timeout_o);
        check("valid_cnt", tot_valid - v0, ev);
        check("short_cnt", tot_short - s0, es);
        check("long_cnt", tot_long - l0, el);
        check("position", int'(position_o), exp_pos);
        check("timeout", int'(timeout_o), int'(exp_timeout));
        if (ev == 1) check("valid_latency", lat, 3);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, v0, s0, l0;
        int bnd[7];
        rst_i = 1'b1; en_i = 1'b1; pwm_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_position", int'(position_o), 0);
        check("rst_valid", int'(valid_o), 0);
        check("rst_short", int'(err_short_o), 0);
        check("rst_long", int'(err_long_o), 0);
        check("rst_timeout", int'(timeout_o), 1);
        @(posedge clk); #1 rst_i = 1'b0;
        repeat (5) @(posedge clk);

        // Directed pulses: mid-scale, near zero, near full scale, short, long.
        run_pulse(MS + 8 * STEP + 2, 20);
        run_pulse(MS + 2, 20);
        run_pulse(MS + 15 * STEP + 10, 20);
        run_pulse(MS * 4 / 5, 20);
        run_pulse(LONG_H + 30, 20);

        bnd = '{MS - 1, MS, MS + STEP - 1, MS + STEP, LONG_H - 1, LONG_H, 1};
        foreach (bnd[i]) run_pulse(bnd[i], 20);

        // Loss of signal: timer runs from the last rising edge.
        h = MS + 4 * STEP + 3;
        run_pulse(h, 20);
        repeat (TB_TO * MS - 25 - h) @(posedge clk);
        @(negedge clk); #1;
        check("timeout_early", int'(timeout_o), 0);
        repeat (10) @(posedge clk);
        @(negedge clk); #1;
        exp_timeout = 1'b1;
        check("timeout_set", int'(timeout_o), 1);
        check("timeout_pos_hold", int'(position_o), exp_pos);
        run_pulse(MS + 4 * STEP + 1, 20);

        // Reset released while the input is high: that pulse must be ignored.
        @(posedge clk); #1 pwm_i = 1'b1;
        repeat (MS + 40) @(posedge clk);
        #1 rst_i = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_i = 1'b0;
        v0 = tot_valid; s0 = tot_short; l0 = tot_long;
        exp_pos = 0; exp_timeout = 1'b1;
        repeat (100) @(posedge clk);
        #1 pwm_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        $display("reset mid-pulse -> strobes=%0d pos=%0d timeout=%0d",
                 (tot_valid - v0) + (tot_short - s0) + (tot_long - l0), position_o, timeout_o);
        check("rstmid_strobes", (tot_valid - v0) + (tot_short - s0) + (tot_long - l0), 0);
        check("rstmid_position", int'(position_o), 0);
        check("rstmid_timeout", int'(timeout_o), 1);
        run_pulse(MS + 12 * STEP + 5, 20);

        // Disable in the middle of the measurement span, re-enable while still high.
        v0 = tot_valid; s0 = tot_short; l0 = tot_long;
        @(posedge clk); #1 pwm_i = 1'b1;
        repeat (MS + 60) @(posedge clk);
        #1 en_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 en_i = 1'b1;
        repeat (30) @(posedge clk);
        #1 pwm_i = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk); #1;
        $display("disable mid-pulse -> strobes=%0d pos=%0d timeout=%0d",
                 (tot_valid - v0) + (tot_short - s0) + (tot_long - l0), position_o, timeout_o);
        check("dis_strobes", (tot_valid - v0) + (tot_short - s0) + (tot_long - l0), 0);
        check("dis_position", int'(position_o), exp_pos);
        check("dis_timeout", int'(timeout_o), int'(exp_timeout));
        run_pulse(MS + 10 * STEP + 7, 20);

        for (int i = 0; i < 40; i++) begin
            run_pulse(int'($urandom_range(LONG_H + 40, 1)), int'($urandom_range(40, 12)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
